// File: rtl/onehot_to_binary_pipe.sv
// rtl/onehot_to_binary_pipe.sv - registered one-hot to binary decoder with valid/ready and error count
// Malformed words decode to the lowest set bit (0 when empty) and flag err.

module onehot_to_binary_pipe #(
  parameter int WID        = 4,
  parameter int ONEHOT_WID = 16,
  parameter int CNT_WID    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ONEHOT_WID-1:0] onehot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WID-1:0]        bin,
  output logic                  err,
  output logic [CNT_WID-1:0]    err_cnt,
  input  logic                  err_clr
);

  localparam logic [ONEHOT_WID-1:0] ONE_OH  = ONEHOT_WID'(1);
  localparam logic [CNT_WID-1:0]    CNT_MAX = '1;
  localparam logic [CNT_WID-1:0]    CNT_ONE = CNT_WID'(1);

  logic                  accept;
  logic [WID-1:0]        dec_bin;
  logic                  dec_zero;
  logic                  dec_multi;
  logic                  dec_err;
  logic [CNT_WID-1:0]    cnt_base;
  logic [CNT_WID-1:0]    cnt_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    dec_bin = '0;
    for (int i = ONEHOT_WID - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        dec_bin = WID'(i);
      end
    end
  end

  assign dec_zero  = ~|onehot;
  assign dec_multi = |(onehot & (onehot - ONE_OH));
  assign dec_err   = dec_zero || dec_multi;

  // Clear takes effect before the increment of the same cycle.
  always_comb begin
    cnt_base = err_clr ? '0 : err_cnt;
    cnt_next = cnt_base;
    if (accept && dec_err && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bin       <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bin       <= dec_bin;
      err       <= dec_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_onehot_to_binary_pipe.sv
// tb/tb_onehot_to_binary_pipe.sv - directed self-checking bench for onehot_to_binary_pipe

module tb_onehot_to_binary_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] onehot;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  bin;
  logic        err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  onehot_to_binary_pipe #(.WID(4), .ONEHOT_WID(16), .CNT_WID(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .onehot    (onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    onehot    = 16'h0000;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_bin", 32'(bin), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    #4;
    rst_n = 1'b1;
    cycle();

    // Exhaustive sweep of legal words at full throughput
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      onehot = 16'h0001 << i;
      cycle();
      chk("sweep_bin", 32'(bin), 32'(i));
      chk("sweep_err", 32'(err), 0);
      chk("sweep_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    cycle();
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_bin_hold", 32'(bin), 15);
    chk("sweep_err_cnt", 32'(err_cnt), 0);

    // Malformed words
    in_valid = 1'b1;
    onehot   = 16'h0000;
    cycle();
    chk("zero_bin", 32'(bin), 0);
    chk("zero_err", 32'(err), 1);
    onehot = 16'h0028;
    cycle();
    chk("multi_bin", 32'(bin), 3);
    chk("multi_err", 32'(err), 1);
    onehot = 16'hFFFF;
    cycle();
    chk("ffff_bin", 32'(bin), 0);
    chk("ffff_err", 32'(err), 1);
    chk("malformed_err_cnt", 32'(err_cnt), 3);
    in_valid = 1'b0;
    cycle();

    // Backpressure
    in_valid = 1'b1;
    onehot   = 16'h0100;
    cycle();
    chk("bp_first_bin", 32'(bin), 8);
    chk("bp_first_err", 32'(err), 0);
    out_ready = 1'b0;
    onehot    = 16'h0004;
    #1;
    chk("bp_in_ready_same_cycle", 32'(in_ready), 0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_stall_bin", 32'(bin), 8);
      chk("bp_stall_in_ready", 32'(in_ready), 0);
      chk("bp_stall_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    cycle();
    chk("bp_next_bin", 32'(bin), 2);
    chk("bp_next_out_valid", 32'(out_valid), 1);
    chk("bp_err_cnt", 32'(err_cnt), 3);
    in_valid = 1'b0;
    cycle();

    // Saturation and clear
    in_valid = 1'b1;
    onehot   = 16'h0000;
    repeat (251) cycle();
    chk("sat_254", 32'(err_cnt), 254);
    cycle();
    chk("sat_255", 32'(err_cnt), 255);
    repeat (8) cycle();
    chk("sat_hold", 32'(err_cnt), 255);
    in_valid = 1'b0;
    err_clr  = 1'b1;
    cycle();
    chk("clr_alone", 32'(err_cnt), 0);
    in_valid = 1'b1;
    cycle();
    chk("clr_with_err", 32'(err_cnt), 1);
    err_clr = 1'b0;
    cycle();
    chk("count_after_clr", 32'(err_cnt), 2);

    // Malformed words offered while stalled are not counted
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("stall_no_count", 32'(err_cnt), 2);

    // Build bin=7, err_cnt=5 then stall and reset asynchronously
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("pre_rst_cnt", 32'(err_cnt), 5);
    onehot = 16'h0080;
    cycle();
    chk("pre_rst_bin", 32'(bin), 7);
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    chk("pre_rst_stall_cnt", 32'(err_cnt), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_bin", 32'(bin), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_in_ready", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
